// File: rtl/regr_pipe.sv
// regr_pipe: DEPTH-stage elastic valid/ready pipeline register.
// Empty stages always accept, so stalled words compact into bubbles.
// A synchronous flush empties every stage. Reset clears state asynchronously.
module regr_pipe #(
    parameter int N          = 1,
    parameter int DEPTH      = 2,
    parameter int CLEAR_DATA = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [N-1:0]     d     [DEPTH];
    logic [DEPTH:0]   r;
    logic [DEPTH-1:0] v_in;
    logic [N-1:0]     d_in  [DEPTH];
    logic             full_from;
    logic             in_hs;
    logic             out_hs;

    // Ready chain. Stage k is ready when out_ready is high or any stage from k
    // to the output is empty. This is the unrolled form of ~v[k] | r[k+1], which
    // avoids a vector that feeds back on itself.
    always_comb begin
        r         = '0;
        full_from = 1'b1;
        r[DEPTH]  = out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            full_from            = full_from & v[DEPTH-1-i];
            r[DEPTH-1-i]         = out_ready | ~full_from;
        end
    end

    // Word offered to each stage: the pipe input for stage 0, otherwise the upstream stage.
    always_comb begin
        v_in    = '0;
        v_in[0] = in_valid & ~flush;
        d_in[0] = in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            v_in[i] = v[i-1];
            d_in[i] = d[i-1];
        end
    end

    assign in_ready  = r[0] & ~flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = v[DEPTH-1] & out_ready;

    // Stage valid bits: flush empties the pipe, otherwise ready stages take their upstream valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r[i]) begin
                    v[i] <= v_in[i];
                end
            end
        end
    end

    // Stage data: written only when a valid word moves in; flush zeroes it if CLEAR_DATA is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            if (CLEAR_DATA != 0) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    d[i] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r[i] && v_in[i]) begin
                    d[i] <= d_in[i];
                end
            end
        end
    end

    // Occupancy: tracks handshakes in and out, cleared by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(in_hs) - CW'(out_hs);
        end
    end

endmodule

// File: tb/tb_regr_pipe.sv
// Scoreboard bench for regr_pipe: unit 0 is N=32/DEPTH=3/CLEAR_DATA=1,
// unit 1 is N=32/DEPTH=2/CLEAR_DATA=0.
module tb_regr_pipe;

    logic        clk;
    logic        reset;
    logic        iv   [2];
    logic        rdy  [2];
    logic [31:0] din  [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [31:0] od   [2];
    logic [1:0]  cnt  [2];
    logic        fl   [2];

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          n_cmp;
    int          n_bad;

    regr_pipe #(.N(32), .DEPTH(3), .CLEAR_DATA(1)) dut0 (
        .clk(clk), .reset(reset), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(din[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .count(cnt[0])
    );

    regr_pipe #(.N(32), .DEPTH(2), .CLEAR_DATA(0)) dut1 (
        .clk(clk), .reset(reset), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(din[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .count(cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and bounds count.
    always @(negedge clk) begin
        if (!reset) begin
            for (int u = 0; u < 2; u++) begin
                logic [31:0] e;
                n_cmp++;
                if (int'(cnt[u]) > ((u == 0) ? 3 : 2)) begin
                    n_bad++;
                    $display("FAIL count_bound u%0d at %0t: got %0d, limit %0d", u, $time, cnt[u], (u == 0) ? 3 : 2);
                end
                if (ov[u] && ordy[u]) begin
                    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL out_word u%0d at %0t: got %0h, expected no word", u, $time, od[u]);
                    end else begin
                        e = (u == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("out_word u%0d", u), od[u], e);
                    end
                end
            end
        end
    end

    // One cycle on unit u: drive, check in_ready/count mid-cycle, record accepted word.
    task automatic step(input int u, input logic v_i, input logic [31:0] d_i, input logic r_o,
                        input logic f_i, input logic exp_rdy, input int exp_cnt);
        iv[u]   = v_i;
        din[u]  = d_i;
        ordy[u] = r_o;
        fl[u]   = f_i;
        @(negedge clk);
        chk($sformatf("in_ready u%0d", u), 32'(rdy[u]), 32'(exp_rdy));
        if (exp_cnt >= 0) chk($sformatf("count u%0d", u), 32'(cnt[u]), exp_cnt);
        if (exp_rdy && v_i) begin
            if (u == 0) q0.push_back(d_i);
            else        q1.push_back(d_i);
        end
        if (f_i) begin
            if (u == 0) q0.delete();
            else        q1.delete();
        end
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
        fl[u] = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            iv[u] = 1'b0; din[u] = '0; ordy[u] = 1'b0; fl[u] = 1'b0;
        end
        #2;
        for (int u = 0; u < 2; u++) begin
            chk("reset out_valid", 32'(ov[u]), 0);
            chk("reset out_data", od[u], 0);
            chk("reset count", 32'(cnt[u]), 0);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Streaming, out_ready=1: word k sees count min(k-1,3) before its edge
        for (int k = 1; k <= 6; k++) step(0, 1'b1, 32'(k), 1'b1, 1'b0, 1'b1, (k - 1 < 3) ? k - 1 : 3);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 3);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        chk("stream drained", 32'(cnt[0]), 0);

        // Fill and stall, out_ready=0
        step(0, 1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 0);
        step(0, 1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1);
        step(0, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 2);
        step(0, 1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 3);
        step(0, 1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 3);
        chk("stall head", od[0], 32'hA);
        step(0, 1'b1, 32'hD, 1'b1, 1'b0, 1'b1, 3);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 3);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        chk("stall drained", 32'(cnt[0]), 0);

        // Bubble collapse, out_ready=0
        step(0, 1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 0);
        step(0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1);
        step(0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1);
        step(0, 1'b1, 32'h6, 1'b0, 1'b0, 1'b1, 1);
        step(0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 2);
        chk("bubble out_valid", 32'(ov[0]), 1);
        chk("bubble out_data", od[0], 32'h5);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 2);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        chk("bubble drained", 32'(cnt[0]), 0);

        // Flush with CLEAR_DATA=1 while three words are held
        step(0, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 0);
        step(0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1);
        step(0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 2);
        step(0, 1'b1, 32'hFF, 1'b0, 1'b1, 1'b0, 3);
        chk("flush0 out_valid", 32'(ov[0]), 0);
        chk("flush0 out_data", od[0], 0);
        chk("flush0 count", 32'(cnt[0]), 0);
        step(0, 1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 0);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        chk("flush0 drained", 32'(cnt[0]), 0);

        // DEPTH=2 full pass-through, then flush with CLEAR_DATA=0
        step(1, 1'b1, 32'h101, 1'b0, 1'b0, 1'b1, 0);
        step(1, 1'b1, 32'h102, 1'b0, 1'b0, 1'b1, 1);
        step(1, 1'b1, 32'h103, 1'b1, 1'b0, 1'b1, 2);
        step(1, 1'b1, 32'h104, 1'b1, 1'b0, 1'b1, 2);
        step(1, 1'b1, 32'hFF, 1'b0, 1'b1, 1'b0, 2);
        chk("flush1 out_valid", 32'(ov[1]), 0);
        chk("flush1 out_data held", od[1], 32'h103);
        chk("flush1 count", 32'(cnt[1]), 0);
        step(1, 1'b1, 32'h105, 1'b1, 1'b0, 1'b1, 0);
        step(1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        step(1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        chk("flush1 drained", 32'(cnt[1]), 0);

        // Async reset between edges with two words held
        step(0, 1'b1, 32'h71, 1'b0, 1'b0, 1'b1, 0);
        step(0, 1'b1, 32'h72, 1'b0, 1'b0, 1'b1, 1);
        chk("pre-reset count", 32'(cnt[0]), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("async out_valid", 32'(ov[0]), 0);
        chk("async out_data", od[0], 0);
        chk("async count", 32'(cnt[0]), 0);
        q0.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        step(0, 1'b1, 32'h81, 1'b1, 1'b0, 1'b1, 0);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        chk("latency early", 32'(ov[0]), 0);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        chk("latency out_valid", 32'(ov[0]), 1);
        chk("latency out_data", od[0], 32'h81);
        step(0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1);
        chk("reset drained", 32'(cnt[0]), 0);

        chk("scoreboard0 empty", q0.size(), 0);
        chk("scoreboard1 empty", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regr_pipe.md
# regr_pipe

Parametrised elastic pipeline register for passing data between CPU stages and between CPU and memory/bus units. It replaces ad-hoc chains of single clear/hold registers with a DEPTH-stage valid/ready pipeline. Stalled words compact into bubbles, and a synchronous flush empties every stage. Throughput is one word per cycle.

## Interface
- N, default 1: data width in bits.
- DEPTH, default 2: number of register stages. Must be ≥ 1.
- CLEAR_DATA, default 1: 1 = flush also zeroes stage data; 0 = flush clears only valid bits.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all stages; highest priority after reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  pipe accepts in_data this cycle.
- in_data  input  N  upstream word.
- out_valid  output  1  valid bit of last stage.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  N  data of last stage.
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

## Operation
- Stages are numbered 0 (input side) to DEPTH-1 (output side). Each stage holds v[k] and d[k].
- out_valid = v[DEPTH-1] and out_data = d[DEPTH-1].
- Ready chain:
  - r[DEPTH] = out_ready.
  - r[k] = ~v[k] | r[k+1].
  - in_ready = r[0] & ~flush.
- The chain is combinational from out_ready to in_ready, so a full pipe accepts a word in the same cycle one leaves.
- Load rule, when r[k]=1 at the edge:
  - Stage 0 takes v[0] ← in_valid & ~flush and d[0] ← in_data.
  - Stage k>0 takes v[k] ← v[k-1] and d[k] ← d[k-1].
  - d[k] is written only when the incoming valid is 1. Otherwise d[k] holds, and only v[k] updates.
- Stages with r[k]=0 hold v and d unchanged.
- Bubble collapse: a valid word advances into an empty downstream stage even while out_ready=0. Words stop only behind other valid words.
- Transfers:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
- count update: count ← count + in_hs − out_hs, computed in DEPTH-safe width. No other source modifies it.
- Flush, at the edge where flush=1:
  - All v ← 0 and count ← 0.
  - d ← 0 if CLEAR_DATA=1, else d holds.
  - in_ready is forced to 0, so no word enters.
  - An output handshake in the flush cycle completes normally; the downstream side treats the word as delivered.
- Reset, asserted at any time:
  - Immediately all v = 0, d = 0, count = 0.
  - Outputs: out_valid=0, out_data=0, count=0, in_ready=1 once reset is deasserted and flush=0.
- Priority: reset > flush > normal load/hold.
- DEPTH=1 is a single skid-less register stage: in_ready = ~v[0] | out_ready.

## Timing
- Latency: a word accepted at edge t into an empty pipe with out_ready=1 shows out_valid=1 after edge t+DEPTH−1. It is stage 0 after edge t and stage DEPTH-1 after DEPTH−1 more edges.
- Throughput: with in_valid=1 and out_ready=1 continuously, one word per cycle in and out, in_ready never drops.
- Full (count=DEPTH) with out_ready=0: in_ready=0, all stages hold, no data change.
- Full with out_ready=1: in_ready=1, simultaneous accept and emit, count stays DEPTH.
- Empty (count=0): out_valid=0, out_data shows the last held d[DEPTH-1] (0 after reset or after a flush with CLEAR_DATA=1).
- Flush and in_valid in the same cycle: the input word is dropped, and in_ready=0 tells upstream so.
- Flush after an async reset release: normal rules apply; no extra recovery cycle.
- count never exceeds DEPTH and never underflows. Reaching either is an assertion failure in the bench.

## Test plan
- Streaming, N=32, DEPTH=3, out_ready=1: send 0x1,0x2,0x3,... back-to-back → 0x1 appears on out_data after 3rd edge, then one word per cycle, in_ready stays 1, count=3 steady.
- Fill and stall, DEPTH=3, out_ready=0: send 0xA,0xB,0xC,0xD → count reaches 3, in_ready=0 while 0xD is held; raise out_ready → 0xA,0xB,0xC,0xD emerge in order, no loss or duplicate.
- Bubble collapse: send 0x5, idle 2 cycles, send 0x6 with out_ready=0 → 0x5 in stage 2 and 0x6 in stage 1 within 2 cycles of 0x6 accept, count=2.
- Full pass-through: DEPTH=2 full, out_ready=1, in_valid=1 → in_ready=1 same cycle, count stays 2, order preserved.
- Flush: pipe holding 3 words, assert flush 1 cycle with in_valid=1 and data 0xFF → in_ready=0 that cycle, next cycle count=0, out_valid=0, out_data=0 (CLEAR_DATA=1); 0xFF never emerges. Repeat with CLEAR_DATA=0 → out_data keeps the old value.
- Async reset mid-stream: assert reset between edges with count=2 → out_valid=0, out_data=0, count=0 before the next edge; after release, the first accepted word emerges with nominal latency.
